// File: rtl/pu_riscv_verilog_pkg.sv
// Shared types for the PU RISC-V front-end redirect logic.
package pu_riscv_verilog_pkg;

    // FENCE.I sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DCWB  = 2'd1,
        ICINV = 2'd2,
        REDIR = 2'd3
    } redir_state_t;

endpackage

// File: rtl/pu_riscv_redirect_ctrl.sv
// PC-redirect arbiter and FENCE.I sequencer feeding the fetch stage.
module pu_riscv_redirect_ctrl
    import pu_riscv_verilog_pkg::*;
#(
    parameter int unsigned        XLEN       = 64,
    parameter logic [XLEN-1:0]    PC_INIT    = XLEN'(64'h8000_0000),
    parameter bit                 HAS_DCACHE = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            bu_flush,
    input  logic            bu_cacheflush,
    input  logic [XLEN-1:0] bu_nxt_pc,
    input  logic            st_flush,
    input  logic [XLEN-1:0] st_nxt_pc,
    input  logic            du_we_pc,
    input  logic [XLEN-1:0] du_dato,
    output logic            dc_flush_req,
    input  logic            dc_flush_ack,
    output logic            ic_inv_req,
    input  logic            ic_inv_ack,
    output logic            if_redirect,
    output logic [XLEN-1:0] if_redirect_pc,
    output logic            pipe_stall,
    output logic            seq_busy
);

    redir_state_t    state_q, state_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            redir_q, redir_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic            dc_req_q, ic_req_q, busy_q;

    // Trap/debug sources merged by priority; trap beats debug
    logic            ext_valid;
    logic [XLEN-1:0] ext_pc;
    assign ext_valid = st_flush | du_we_pc;
    assign ext_pc    = st_flush ? st_nxt_pc : du_dato;

    // Next-state, pending target and redirect selection
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        redir_d    = 1'b0;
        redir_pc_d = redir_pc_q;
        unique case (state_q)
            IDLE: begin
                if (ext_valid) begin
                    redir_d    = 1'b1;
                    redir_pc_d = ext_pc;
                end else if (bu_flush && bu_cacheflush) begin
                    pend_d  = bu_nxt_pc;
                    state_d = HAS_DCACHE ? DCWB : ICINV;
                end else if (bu_flush) begin
                    redir_d    = 1'b1;
                    redir_pc_d = bu_nxt_pc;
                end
            end
            DCWB: begin
                if (ext_valid) pend_d = ext_pc;
                if (dc_flush_ack) state_d = ICINV;
            end
            ICINV: begin
                if (ext_valid) pend_d = ext_pc;
                if (ic_inv_ack) begin
                    state_d    = REDIR;
                    redir_d    = 1'b1;
                    redir_pc_d = ext_valid ? ext_pc : pend_q;
                end
            end
            REDIR: begin
                state_d = IDLE;
                // Trap/debug arriving now is serviced as a plain request
                if (ext_valid) begin
                    redir_d    = 1'b1;
                    redir_pc_d = ext_pc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, target and registered outputs; reset issues the boot redirect
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            pend_q     <= PC_INIT;
            redir_q    <= 1'b1;
            redir_pc_q <= PC_INIT;
            dc_req_q   <= 1'b0;
            ic_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            redir_q    <= redir_d;
            redir_pc_q <= redir_pc_d;
            dc_req_q   <= (state_d == DCWB);
            ic_req_q   <= (state_d == ICINV);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign if_redirect    = redir_q;
    assign if_redirect_pc = redir_pc_q;
    assign dc_flush_req   = dc_req_q;
    assign ic_inv_req     = ic_req_q;
    assign pipe_stall     = busy_q;
    assign seq_busy       = busy_q;

endmodule

// File: tb/tb_pu_riscv_redirect_ctrl.sv
// Bench: two DUTs (with/without D-cache) on shared stimulus, checked against a reference model.
module tb_pu_riscv_redirect_ctrl;

    localparam int unsigned XLEN    = 64;
    localparam logic [63:0] PC_INIT = 64'h8000_0000;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic bu_flush = 1'b0, bu_cacheflush = 1'b0, st_flush = 1'b0, du_we_pc = 1'b0;
    logic dc_flush_ack = 1'b0, ic_inv_ack = 1'b0;
    logic [63:0] bu_nxt_pc = '0, st_nxt_pc = '0, du_dato = '0;

    logic        dc_req [2];
    logic        ic_req [2];
    logic        redir  [2];
    logic [63:0] rpc    [2];
    logic        stall  [2];
    logic        busy   [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pu_riscv_redirect_ctrl #(.XLEN(XLEN), .PC_INIT(PC_INIT), .HAS_DCACHE(1'b1)) u_dut_dc (
        .clk(clk), .rstn(rstn),
        .bu_flush(bu_flush), .bu_cacheflush(bu_cacheflush), .bu_nxt_pc(bu_nxt_pc),
        .st_flush(st_flush), .st_nxt_pc(st_nxt_pc),
        .du_we_pc(du_we_pc), .du_dato(du_dato),
        .dc_flush_req(dc_req[1]), .dc_flush_ack(dc_flush_ack),
        .ic_inv_req(ic_req[1]), .ic_inv_ack(ic_inv_ack),
        .if_redirect(redir[1]), .if_redirect_pc(rpc[1]),
        .pipe_stall(stall[1]), .seq_busy(busy[1])
    );

    pu_riscv_redirect_ctrl #(.XLEN(XLEN), .PC_INIT(PC_INIT), .HAS_DCACHE(1'b0)) u_dut_nodc (
        .clk(clk), .rstn(rstn),
        .bu_flush(bu_flush), .bu_cacheflush(bu_cacheflush), .bu_nxt_pc(bu_nxt_pc),
        .st_flush(st_flush), .st_nxt_pc(st_nxt_pc),
        .du_we_pc(du_we_pc), .du_dato(du_dato),
        .dc_flush_req(dc_req[0]), .dc_flush_ack(dc_flush_ack),
        .ic_inv_req(ic_req[0]), .ic_inv_ack(ic_inv_ack),
        .if_redirect(redir[0]), .if_redirect_pc(rpc[0]),
        .pipe_stall(stall[0]), .seq_busy(busy[0])
    );

    // Reference model: phase 0 idle, 1 writing back D$, 2 invalidating I$, 3 final redirect
    int          m_phase [2];
    logic [63:0] m_pend  [2];
    bit          m_redir [2];
    logic [63:0] m_pc    [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0;
            m_pend[k]  = PC_INIT;
            m_redir[k] = 1'b1;
            m_pc[k]    = PC_INIT;
        end
    endfunction

    function automatic void model_step(input int k);
        bit          ext   = st_flush | du_we_pc;
        logic [63:0] extpc = st_flush ? st_nxt_pc : du_dato;
        m_redir[k] = 1'b0;
        if (m_phase[k] == 0) begin
            if (ext) begin
                m_redir[k] = 1'b1; m_pc[k] = extpc;
            end else if (bu_flush && bu_cacheflush) begin
                m_pend[k]  = bu_nxt_pc;
                m_phase[k] = (k == 1) ? 1 : 2;
            end else if (bu_flush) begin
                m_redir[k] = 1'b1; m_pc[k] = bu_nxt_pc;
            end
        end else if (m_phase[k] == 3) begin
            m_phase[k] = 0;
            if (ext) begin
                m_redir[k] = 1'b1; m_pc[k] = extpc;
            end
        end else begin
            if (ext) m_pend[k] = extpc;
            if (m_phase[k] == 1 && dc_flush_ack) m_phase[k] = 2;
            else if (m_phase[k] == 2 && ic_inv_ack) begin
                m_phase[k] = 3;
                m_redir[k] = 1'b1;
                m_pc[k]    = m_pend[k];
            end
        end
    endfunction

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("redirect[%0d]", k), 64'(redir[k]), 64'(m_redir[k]));
            if (m_redir[k]) chk($sformatf("redirect_pc[%0d]", k), rpc[k], m_pc[k]);
            chk($sformatf("dc_req[%0d]", k), 64'(dc_req[k]), 64'(m_phase[k] == 1));
            chk($sformatf("ic_req[%0d]", k), 64'(ic_req[k]), 64'(m_phase[k] == 2));
            chk($sformatf("stall[%0d]", k), 64'(stall[k]), 64'(m_phase[k] != 0));
            chk($sformatf("busy[%0d]", k), 64'(busy[k]), 64'(m_phase[k] != 0));
        end
    endtask

    task automatic clear_inputs();
        bu_flush = 0; bu_cacheflush = 0; st_flush = 0; du_we_pc = 0;
        dc_flush_ack = 0; ic_inv_ack = 0;
    endtask

    // One clock: model advances on the edge, DUTs are checked on the falling edge
    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare_all();
    endtask

    // Asynchronous reset applied mid-cycle, released on a falling edge
    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        #2;
        compare_all();
        @(negedge clk);
        compare_all();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // FENCE.I with acks after dc_n / ic_n request cycles on the D-cache DUT
    task automatic run_fence(input logic [63:0] tgt, input int dc_n, input int ic_n,
                             input bit inject, input logic [63:0] inj_pc,
                             input logic [63:0] final_pc);
        int dc_cnt = 0, ic_cnt = 0, rd_cnt = 0, dc0_cnt = 0;
        bit done = 0;
        logic [63:0] last_pc = '0;
        bu_flush = 1; bu_cacheflush = 1; bu_nxt_pc = tgt;
        cycle();
        clear_inputs();
        for (int i = 0; i < 60; i++) begin
            dc_cnt  += int'(dc_req[1]);
            ic_cnt  += int'(ic_req[1]);
            dc0_cnt += int'(dc_req[0]);
            if (redir[1]) begin rd_cnt++; last_pc = rpc[1]; end
            if (!busy[1]) begin done = 1; break; end
            dc_flush_ack = dc_req[1] && (dc_cnt == dc_n);
            ic_inv_ack   = ic_req[1] && (ic_cnt == ic_n);
            st_flush     = inject && ic_req[1] && (ic_cnt == 1);
            st_nxt_pc    = inj_pc;
            cycle();
            clear_inputs();
        end
        chk("fence_done", 64'(done), 64'd1);
        chk("fence_dc_cycles", 64'(dc_cnt), 64'(dc_n));
        chk("fence_ic_cycles", 64'(ic_cnt), 64'(ic_n));
        chk("fence_redirects", 64'(rd_cnt), 64'd1);
        chk("fence_target", last_pc, final_pc);
        chk("nodc_dc_req_cycles", 64'(dc0_cnt), 64'd0);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        @(negedge clk);
        do_reset();

        // Boot redirect lasts exactly one cycle
        chk("boot_redirect", 64'(redir[1]), 64'd1);
        chk("boot_pc", rpc[1], 64'h8000_0000);
        cycle();
        chk("boot_redirect_clear", 64'(redir[1]), 64'd0);

        // Plain branch redirect
        bu_flush = 1; bu_nxt_pc = 64'h8000_0100;
        cycle();
        clear_inputs();
        chk("bu_redirect", 64'(redir[1]), 64'd1);
        chk("bu_pc", rpc[1], 64'h8000_0100);
        chk("bu_busy", 64'(busy[1]), 64'd0);
        cycle();
        chk("bu_one_cycle", 64'(redir[1]), 64'd0);

        // Same-cycle priority: trap beats debug beats branch
        st_flush = 1; st_nxt_pc = 64'h200;
        du_we_pc = 1; du_dato = 64'h300;
        bu_flush = 1; bu_nxt_pc = 64'h400;
        cycle();
        clear_inputs();
        chk("prio_pc", rpc[1], 64'h200);
        cycle();
        chk("prio_single", 64'(redir[1]), 64'd0);

        // FENCE.I sequences
        run_fence(64'h8000_0044, 5, 3, 1'b0, 64'h0, 64'h8000_0044);
        run_fence(64'h8000_0080, 1, 2, 1'b1, 64'h1000, 64'h1000);
        run_fence(64'h8000_00c0, 1, 1, 1'b0, 64'h0, 64'h8000_00c0);

        // Stray acks in idle change nothing
        dc_flush_ack = 1; ic_inv_ack = 1;
        cycle();
        clear_inputs();
        chk("stray_ack_busy", 64'(busy[1]), 64'd0);
        chk("stray_ack_ic", 64'(ic_req[0]), 64'd0);

        // Reset in the middle of a sequence
        bu_flush = 1; bu_cacheflush = 1; bu_nxt_pc = 64'h8000_0200;
        cycle();
        clear_inputs();
        cycle();
        @(posedge clk);
        #3;
        do_reset();
        chk("midreset_redirect", 64'(redir[1]), 64'd1);
        chk("midreset_pc", rpc[1], PC_INIT);
        cycle();

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r = $urandom_range(0, 99);
            bu_flush      = (r < 25);
            bu_cacheflush = bu_flush && ($urandom_range(0, 3) == 0);
            st_flush      = ($urandom_range(0, 15) == 0);
            du_we_pc      = ($urandom_range(0, 15) == 0);
            bu_nxt_pc     = {$urandom, $urandom};
            st_nxt_pc     = {$urandom, $urandom};
            du_dato       = {$urandom, $urandom};
            dc_flush_ack  = ($urandom_range(0, 3) == 0);
            ic_inv_ack    = ($urandom_range(0, 3) == 0);
            cycle();
        end
        clear_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pu_riscv_redirect_ctrl.md
Name: pu_riscv_redirect_ctrl

Overview:
Central PC-redirect arbiter and FENCE.I sequencer between the branch unit, state/trap unit, debug unit and the fetch stage. It picks one redirect source per cycle by fixed priority and drives a single registered redirect to IF. For FENCE.I it stalls the pipeline, runs the D-cache writeback and I-cache invalidate handshakes in order, then issues the deferred redirect.

Parameters:
XLEN, 64, PC width
PC_INIT, 'h8000_0000, redirect target issued after reset
HAS_DCACHE, 1, 0 = skip the D-cache writeback phase

Ports:
clk  in  1  clock
rstn  in  1  async active-low reset
bu_flush  in  1  branch/JALR mispredict redirect request
bu_cacheflush  in  1  FENCE.I request, valid only with bu_flush=1
bu_nxt_pc  in  XLEN  branch-unit target
st_flush  in  1  trap/xRET redirect request
st_nxt_pc  in  XLEN  trap target
du_we_pc  in  1  debug PC write
du_dato  in  XLEN  debug PC value
dc_flush_req  out  1  D-cache writeback-all request (level)
dc_flush_ack  in  1  D-cache done pulse
ic_inv_req  out  1  I-cache invalidate-all request (level)
ic_inv_ack  in  1  I-cache done pulse
if_redirect  out  1  registered redirect strobe to IF
if_redirect_pc  out  XLEN  redirect target
pipe_stall  out  1  hold IF/ID/EX while a FENCE.I sequence runs
seq_busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rstn low): if_redirect=1, if_redirect_pc=PC_INIT, dc_flush_req=0, ic_inv_req=0, pipe_stall=0, seq_busy=0, FSM=IDLE, pending target=PC_INIT. The first clock after release clears if_redirect, giving exactly one post-reset redirect cycle.
- Source priority, highest first: st_flush, then du_we_pc, then bu_flush. Lower-priority requests in the same cycle are dropped; no queueing.
- Plain redirect (IDLE, no cacheflush): request in cycle N gives if_redirect=1 with the selected PC in N+1, for one cycle only.
- FSM states: IDLE, DCWB, ICINV, REDIR.
- IDLE → DCWB when bu_flush & bu_cacheflush & ~st_flush & ~du_we_pc. If HAS_DCACHE=0, go to ICINV instead.
  - Capture bu_nxt_pc into the pending target.
  - No if_redirect is issued in this case.
- DCWB: dc_flush_req=1. On dc_flush_ack go to ICINV; dc_flush_req drops the next cycle.
- ICINV: ic_inv_req=1. On ic_inv_ack go to REDIR.
- REDIR: if_redirect=1 with the pending target for one cycle, then go to IDLE.
- pipe_stall and seq_busy are 1 in DCWB, ICINV and REDIR. Both rise the cycle after the FENCE.I is accepted and fall on the cycle FSM returns to IDLE.
- Acks are ignored unless the matching req is high. An ack in the first cycle that req is high is legal.
- bu_flush and bu_cacheflush are ignored while seq_busy=1, because the pipeline is stalled.
- st_flush or du_we_pc during DCWB/ICINV:
  - overwrite the pending target (st_flush wins if both);
  - no immediate redirect;
  - the cache operations are not aborted;
  - the REDIR state uses the new target.
- st_flush or du_we_pc in the REDIR cycle: that request is redirected one cycle later, as a normal IDLE request.
- Targets are passed through unmodified; no alignment masking is done here, since misalignment is flagged by the branch unit.
- Reset mid-sequence: all requests drop immediately and the post-reset redirect to PC_INIT applies.

Decomposition:
- pu_riscv_verilog_pkg gets the FSM state enum typedef: redir_state_t {IDLE, DCWB, ICINV, REDIR}.
- No sub-module: one FSM, one target register and the priority mux, about 150–250 lines of RTL.

Test Plan:
- Reset release, PC_INIT=0x80000000 → if_redirect=1, pc=0x80000000 for exactly 1 cycle, then 0.
- bu_flush, bu_nxt_pc=0x80000100, one cycle → next cycle if_redirect=1 with 0x80000100, seq_busy stays 0.
- Same cycle st_flush (st_nxt_pc=0x200) + du_we_pc (0x300) + bu_flush (0x400) → single redirect to 0x200.
- FENCE.I, target 0x80000044, dc_ack after 5 cycles, ic_ack after 3 cycles → dc_req 5 cycles, then ic_req 3 cycles, then one redirect to 0x80000044; pipe_stall high throughout; 0 redirects in between.
- FENCE.I with st_flush (0x1000) during ICINV → ic handshake completes, final redirect goes to 0x1000, no earlier redirect.
- HAS_DCACHE=0 FENCE.I → dc_flush_req never asserts, ICINV entered directly; stray dc_flush_ack/ic_inv_ack pulses in IDLE → no state change.
